// File: rtl/mul_div_unit.sv
// Iterative N-bit MUL/UDIV/SDIV unit: one bit per cycle, single write-back beat.
// Shift-add multiply and restoring divide share one accumulator and two operand registers.
module mul_div_unit #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [4:0]   rd,
  output logic         busy,
  output logic         done,
  output logic         we,
  output logic [4:0]   wa,
  output logic [N-1:0] wd
);

  localparam int CW = $clog2(N);
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_UDIV = 2'b01;
  localparam logic [1:0] OP_SDIV = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic            neg_q, neg_d;
  logic            bzero_q, bzero_d;
  logic [N-1:0]    acc_q, acc_d;
  logic [N-1:0]    x_q, x_d;
  logic [N-1:0]    y_q, y_d;
  logic            done_q, done_d;
  logic            we_q, we_d;
  logic [4:0]      wa_q, wa_d;
  logic [N-1:0]    wd_q, wd_d;
  logic [N:0]      rem_sh;
  logic [N:0]      diff;

  function automatic logic [N-1:0] abs_val(input logic signed [N-1:0] v);
    return v[N-1] ? -v : v;
  endfunction

  function automatic logic [N-1:0] neg_val(input logic [N-1:0] v);
    return ~v + N'(1);
  endfunction

  function automatic logic [N-1:0] final_result(input logic [1:0] o, input logic [N-1:0] prod,
                                                input logic [N-1:0] quo, input logic neg,
                                                input logic bz);
    case (o)
      OP_MUL:  return prod;
      OP_UDIV: return bz ? '0 : quo;
      OP_SDIV: return bz ? '0 : (neg ? neg_val(quo) : quo);
      default: return '0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    neg_d   = neg_q;
    bzero_d = bzero_q;
    acc_d   = acc_q;
    x_d     = x_q;
    y_d     = y_q;
    done_d  = 1'b0;
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    rem_sh  = '0;
    diff    = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          op_d    = op;
          rd_d    = rd;
          acc_d   = '0;
          bzero_d = (b == '0);
          if (op == OP_SDIV) begin
            x_d   = abs_val(a);
            y_d   = abs_val(b);
            neg_d = a[N-1] ^ b[N-1];
          end else begin
            x_d   = a;
            y_d   = b;
            neg_d = 1'b0;
          end
        end
      end
      S_RUN: begin
        if (op_q == OP_MUL) begin
          if (y_q[0]) acc_d = acc_q + x_q;
          x_d = x_q << 1;
          y_d = y_q >> 1;
        end else begin
          // Dividend bits shift out of x while quotient bits shift in behind them.
          rem_sh = {acc_q, x_q[N-1]};
          diff   = rem_sh - {1'b0, y_q};
          if (!diff[N]) begin
            acc_d = diff[N-1:0];
            x_d   = {x_q[N-2:0], 1'b1};
          end else begin
            acc_d = rem_sh[N-1:0];
            x_d   = {x_q[N-2:0], 1'b0};
          end
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N-1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          we_d    = (rd_q != 5'd31);
          wa_d    = rd_q;
          wd_d    = final_result(op_q, acc_d, x_d, neg_q, bzero_q);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q    <= op_d;
    rd_q    <= rd_d;
    neg_q   <= neg_d;
    bzero_q <= bzero_d;
    acc_q   <= acc_d;
    x_q     <= x_d;
    y_q     <= y_d;
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign we   = we_q;
  assign wa   = wa_q;
  assign wd   = wd_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed vector table, handshake/reset sequences,
// and random operations compared against an arithmetic reference model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [63:0] a, b;
  logic [4:0]  rd;
  logic        busy, done, we;
  logic [4:0]  wa;
  logic [63:0] wd;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.N(64)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .rd(rd),
    .busy(busy), .done(done), .we(we), .wa(wa), .wd(wd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
    logic signed [63:0] sx, sy;
    sx = x;
    sy = y;
    case (o)
      2'b00: return x * y;
      2'b01: return (y == 0) ? 64'd0 : x / y;
      2'b10: begin
        if (y == 0) return 64'd0;
        if (x == 64'h8000_0000_0000_0000 && y == 64'hFFFF_FFFF_FFFF_FFFF) return x;
        return sx / sy;
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic check_op(input string nm, input logic [1:0] o, input logic [63:0] av,
                          input logic [63:0] bv, input logic [4:0] r, input logic [63:0] exp);
    int j;
    logic [63:0] got_wd;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv; rd = r;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; rd = 5'($urandom);
    chk({nm, "_busy"}, busy, 1'b1);
    j = 0;
    while (done !== 1'b1 && j < 200) begin
      @(negedge clk);
      j++;
    end
    chk({nm, "_latency"}, j, 64);
    got_wd = wd;
    chk({nm, "_wd"}, wd, exp);
    chk({nm, "_wa"}, wa, r);
    chk({nm, "_we"}, we, (r != 5'd31));
    @(negedge clk);
    chk({nm, "_idle"}, {busy, done, we}, 3'b000);
    @(negedge clk);
    chk({nm, "_wd_hold"}, wd, got_wd);
  endtask

  initial begin
    int nd;
    int dt [4];
    logic [63:0] dw [4];
    int dcnt;
    logic [63:0] cap_wd;
    logic [4:0]  cap_wa;
    logic [1:0]  ro;
    logic [63:0] ra, rb;
    logic [4:0]  rr;

    vecs[0]  = '{2'b00, 64'd7, 64'd6, 5'd3, 64'd42};
    vecs[1]  = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4, 64'd1};
    vecs[2]  = '{2'b01, 64'd100, 64'd7, 5'd5, 64'd14};
    vecs[3]  = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd6, 64'h7FFF_FFFF_FFFF_FFFF};
    vecs[4]  = '{2'b01, 64'd55, 64'd0, 5'd7, 64'd0};
    vecs[5]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd8, 64'hFFFF_FFFF_FFFF_FFF2};
    vecs[6]  = '{2'b10, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd9, 64'hFFFF_FFFF_FFFF_FFF2};
    vecs[7]  = '{2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10, 64'h8000_0000_0000_0000};
    vecs[8]  = '{2'b10, 64'd5, 64'd0, 5'd11, 64'd0};
    vecs[9]  = '{2'b00, 64'd3, 64'd4, 5'd31, 64'd12};
    vecs[10] = '{2'b11, 64'd123, 64'd456, 5'd12, 64'd0};
    vecs[11] = '{2'b10, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 5'd13, 64'd14};

    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_we", we, 1'b0);
    chk("reset_wa", wa, 5'd0);
    chk("reset_wd", wd, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp);

    // Start pulses during RUN and during DONE must both be ignored.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 64'd7; b = 64'd6; rd = 5'd3;
    @(posedge clk);
    @(negedge clk);
    dcnt = 0; cap_wd = '0; cap_wa = '0;
    for (int j = 0; j < 150; j++) begin
      if (j == 10 || j == 64) begin
        start = 1'b1; op = 2'b01; a = 64'd1000; b = 64'd3; rd = 5'd9;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dcnt++;
        cap_wd = wd;
        cap_wa = wa;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("hs_done_count", dcnt, 1);
    chk("hs_wd", cap_wd, 64'd42);
    chk("hs_wa", cap_wa, 5'd3);
    chk("hs_idle", busy, 1'b0);

    // Start held high: one operation per 66 cycles.
    start = 1'b1; op = 2'b00; a = 64'd3; b = 64'd5; rd = 5'd2;
    nd = 0;
    for (int t = 1; t <= 220; t++) begin
      @(negedge clk);
      if (done) begin
        if (nd < 4) begin
          dt[nd] = t;
          dw[nd] = wd;
        end
        nd++;
      end
    end
    start = 1'b0;
    chk("b2b_count", nd, 3);
    if (nd >= 3) begin
      chk("b2b_period1", dt[1] - dt[0], 66);
      chk("b2b_period2", dt[2] - dt[1], 66);
      for (int i = 0; i < 3; i++) chk($sformatf("b2b_wd%0d", i), dw[i], 64'd15);
    end
    for (int t = 0; t < 200 && busy; t++) @(negedge clk);
    chk("b2b_idle", busy, 1'b0);

    // Reset during iteration 30 of a UDIV aborts with no write-back.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 64'd1000; b = 64'd7; rd = 5'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_we", we, 1'b0);
    chk("rst_wa", wa, 5'd0);
    chk("rst_wd", wd, 64'd0);
    reset = 1'b0;
    dcnt = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (done || we) dcnt++;
    end
    chk("rst_no_done", dcnt, 0);
    check_op("post_rst", 2'b01, 64'd1000, 64'd7, 5'd5, 64'd142);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: rb = 64'd0;
        1: rb = 64'($urandom_range(1, 100));
        2: rb = {32'hFFFF_FFFF, $urandom};
        default: rb = {$urandom, $urandom};
      endcase
      if (i % 3 == 0) ra = 64'($signed($urandom_range(0, 2000)) - 1000);
      rr = 5'($urandom);
      check_op($sformatf("rnd%0d", i), ro, ra, rb, rr, model(ro, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
